// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and default parameters for uart_rx
package uart_pkg;
    localparam int DATA_BITS_DEF = 8;
    localparam int CLKS_PER_BIT_DEF = 16;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an idle-high asynchronous line
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {q, m} <= 2'b11;
        else {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: mid-bit sampling UART receiver, 8N1 default; even parity with UART_RX_PARITY_EN
module uart_rx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 parity_error,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] NBITS = BW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_nx;
    logic rx_s, rx_prev, tick, par_bad, valid_nx, ferr_nx;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] sh;
    sync_2ff u_sync (.clk(clk), .reset_n(reset_n), .d(rxd), .q(rx_s));
    // START waits half a bit so every later tick lands mid-bit
    assign tick = (state == START) ? (cnt == HALF) : (cnt == LAST);
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rx_prev && !rx_s) state_nx = START;
            START:   if (tick) state_nx = rx_s ? IDLE : DATA;
            DATA:    if (tick && bit_cnt == NBITS) state_nx = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
            PARITY:  if (tick) state_nx = STOP;
`endif
            STOP:    if (tick) state_nx = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        valid_nx = state == STOP && tick && rx_s && !par_bad;
        ferr_nx = state == STOP && tick && !rx_s;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            rx_prev <= 1'b1;
            cnt <= '0;
            bit_cnt <= '0;
            sh <= '0;
            data <= '0;
            valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_prev <= rx_s;
            cnt <= (state == IDLE || state == BREAK || tick) ? '0 : cnt + 1'b1;
            bit_cnt <= (state == DATA) ? bit_cnt + BW'(tick) : '0;
            if (state == DATA && tick) sh <= {rx_s, sh[DATA_BITS-1:1]};
            if (valid_nx) data <= sh;
            valid <= valid_nx;
            frame_error <= ferr_nx;
        end
`ifdef UART_RX_PARITY_EN
    logic par_bit;
    assign par_bad = ^{sh, par_bit};
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            par_bit <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (state == PARITY && tick) par_bit <= rx_s;
            parity_error <= state == STOP && tick && rx_s && par_bad;
        end
`else
    assign par_bad = 1'b0;
    assign parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; define UART_RX_PARITY_EN to cover parity frames
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int LAT = 3 + (9 + P) * CPB + CPB / 2;
    localparam int FRAME = (10 + P) * CPB;

    typedef struct {
        int kind;
        int d;
    } ev_t;

    logic clk, reset_n, rxd;
    logic [7:0] data;
    logic valid, frame_error, parity_error, busy;
    int n_cmp, n_err, cyc, t_start;
    ev_t sb[$];
    int vq[$];

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .rxd(rxd), .data(data), .valid(valid),
        .frame_error(frame_error), .parity_error(parity_error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int kind, input int d);
        ev_t e;
        e.kind = kind;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic par, input logic stop_lvl, input int stop_len);
        logic [8:0] fr;
        fr = {par, b};
        t_start = cyc;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8 + P; i++) begin
            rxd = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_lvl;
        repeat (stop_len) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (valid || frame_error || parity_error) begin
            ev_t e;
            int k;
            k = valid ? 0 : frame_error ? 1 : 2;
            chk("valid_ferr_exclusive", int'(valid && frame_error), 0);
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got kind %0d data %0h, expected no event", k, data);
            end else begin
                e = sb.pop_front();
                if (e.kind != k || int'(data) != e.d) begin
                    n_err++;
                    $display("FAIL event: got kind %0d data %0h, expected kind %0d data %0h", k, data, e.kind, e.d);
                end
            end
            if (valid) vq.push_back(cyc);
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int bc, t0, t1;
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        rxd = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data", int'(data), 0);
        chk("rst_flags", int'({valid, frame_error, parity_error, busy}), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        vq.delete();
        expect_ev(0, 8'hA5);
        fork
            send(8'hA5, 1'b0, 1'b1, CPB);
            begin
                repeat (CPB * 5) @(negedge clk);
                chk("a5_busy_mid", int'(busy), 1);
            end
        join
        chk("a5_latency", vq.size() > 0 ? vq[0] - t_start : -1, LAT);
        chk("a5_data", int'(data), 8'hA5);

        bc = 0;
        rxd = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (i == 4) rxd = 1'b1;
            @(negedge clk);
            bc += int'(busy);
        end
        chk("glitch_busy_short", int'(bc > 0 && bc < 10), 1);
        chk("glitch_data", int'(data), 8'hA5);

        expect_ev(1, 8'hA5);
        send(8'h3C, 1'b0, 1'b0, 40);
        chk("break_busy", int'(busy), 1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_exit", int'(busy), 0);
        repeat (CPB) @(negedge clk);
        expect_ev(0, 8'h11);
        send(8'h11, 1'b0, 1'b1, CPB);

        vq.delete();
        expect_ev(0, 8'h00);
        expect_ev(0, 8'hFF);
        send(8'h00, 1'b0, 1'b1, CPB);
        send(8'hFF, 1'b0, 1'b1, CPB);
        repeat (4) @(negedge clk);
        t0 = vq.size() > 0 ? vq[0] : 0;
        t1 = vq.size() > 1 ? vq[1] : 0;
        chk("b2b_spacing", t1 - t0, FRAME);
        chk("b2b_data", int'(data), 8'hFF);

        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = (i == 1 || i == 3) ? 1'b1 : 1'b0;
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_data", int'(data), 0);
        chk("midrst_flags", int'({valid, frame_error, parity_error, busy}), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_idle", int'(busy), 0);
        expect_ev(0, 8'h81);
        send(8'h81, 1'b0, 1'b1, CPB);

`ifdef UART_RX_PARITY_EN
        expect_ev(2, 8'h81);
        send(8'h07, 1'b0, 1'b1, CPB);
        chk("par_bad_data", int'(data), 8'h81);
        expect_ev(0, 8'h07);
        send(8'h07, 1'b1, 1'b1, CPB);
`endif

        repeat (40) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("final_idle", int'(busy), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
